// File: rtl/painel_nivel2.sv
// painel_nivel2: front-panel controller for the level-2 microwave timer.
// Scans the digit pad and the start/stop buttons, turns accepted presses into
// BCD load strobes for the timer and runs the cook/pause/done state machine.
module painel_nivel2 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BEEP_CYCLES     = 8
) (
  input  logic       CLK,
  input  logic       clearn,
  input  logic [9:0] keys,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic [3:0] data,
  output logic       loadn,
  output logic       enable,
  output logic       timer_clearn,
  output logic       mag_on,
  output logic       beep
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COOK  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bit 11 = stop, bit 10 = start, bits 9:0 = digit keys, all active-high.
  logic [11:0] raw_in;
  logic [11:0] sync1, sync2, held;
  logic        door_s1, door_s2, done_s1, done_s2;
  logic [CW-1:0] press_cnt, rel_cnt;
  logic        locked;
  logic        any_active, accept;
  logic        evt_stop, evt_start, evt_digit;
  logic [3:0]  key_val;

  logic [1:0]  state;
  logic [1:0]  digit_cnt;
  logic [BW-1:0] beep_cnt;

  assign raw_in = {~stopn, ~startn, keys};

  // Two-flop synchronisers for every asynchronous input.
  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      sync1   <= '0;
      sync2   <= '0;
      door_s1 <= 1'b0;
      door_s2 <= 1'b0;
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      door_s1 <= door_closed;
      door_s2 <= door_s1;
      done_s1 <= timer_done;
      done_s2 <= done_s1;
    end
  end

  assign any_active = |sync2;
  assign accept     = (press_cnt == DB_MAX) && !locked;

  // Debounce: count how long the same button pattern has been stable, and
  // hold off new events until everything has been released long enough.
  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      held      <= '0;
      press_cnt <= '0;
      rel_cnt   <= '0;
      locked    <= 1'b0;
    end else begin
      held <= sync2;
      if (!any_active)
        press_cnt <= '0;
      else if (sync2 != held)
        press_cnt <= CW'(1);
      else if (press_cnt != DB_MAX)
        press_cnt <= press_cnt + CW'(1);

      if (any_active)
        rel_cnt <= '0;
      else if (rel_cnt != DB_MAX)
        rel_cnt <= rel_cnt + CW'(1);

      if (accept)
        locked <= 1'b1;
      else if (rel_cnt == DB_MAX)
        locked <= 1'b0;
    end
  end

  // Stop beats start, and either one masks any digit pressed with it.
  assign evt_stop  = accept &  held[11];
  assign evt_start = accept & ~held[11] &  held[10];
  assign evt_digit = accept & ~held[11] & ~held[10] & (|held[9:0]);

  // Lowest-numbered pressed digit wins.
  always_comb begin
    key_val = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (held[i]) key_val = 4'(i);
    end
  end

  // Cooking state machine; strobes default high and drop for one cycle.
  always_ff @(posedge CLK or negedge clearn) begin
    if (!clearn) begin
      state        <= ST_IDLE;
      digit_cnt    <= 2'd0;
      data         <= 4'd0;
      loadn        <= 1'b1;
      timer_clearn <= 1'b1;
      beep_cnt     <= '0;
    end else begin
      loadn        <= 1'b1;
      timer_clearn <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (evt_digit) begin
            if (digit_cnt != 2'd3) begin
              data      <= key_val;
              loadn     <= 1'b0;
              digit_cnt <= digit_cnt + 2'd1;
            end
          end else if (evt_start) begin
            if (door_s2 && !done_s2) state <= ST_COOK;
          end else if (evt_stop) begin
            timer_clearn <= 1'b0;
            digit_cnt    <= 2'd0;
          end
        end
        ST_COOK: begin
          if (done_s2) begin
            state    <= ST_DONE;
            beep_cnt <= BW'(BEEP_CYCLES - 1);
          end else if (!door_s2 || evt_stop) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (evt_start && door_s2) begin
            state <= ST_COOK;
          end else if (evt_stop) begin
            timer_clearn <= 1'b0;
            digit_cnt    <= 2'd0;
            state        <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (accept || beep_cnt == '0) begin
            state     <= ST_IDLE;
            digit_cnt <= 2'd0;
          end else begin
            beep_cnt <= beep_cnt - BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign enable = (state == ST_COOK);
  assign mag_on = (state == ST_COOK);
  assign beep   = (state == ST_DONE);

endmodule
